// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//  - ctrl_state_e : FSM state, RUN or MEM_WAIT (multi-cycle SRAM access in progress)
//  - DEF_*        : default counter width and watchdog limits
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_HAZ_MAX     = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
//  clk, rst : clock and synchronous active-high reset
//  inc      : count one qualifying cycle
//  clr      : zero the counter; wins over a same-cycle inc
//  q        : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: owns the freeze/flush enables of the 5-stage
// pipeline registers, tracks multi-cycle SRAM waits, runs two watchdogs and
// keeps three saturating performance counters.
// Ports:
//  clk, rst          : clock, synchronous active-high reset
//  hazard_detected   : RAW stall request for the instruction in ID
//  branch_taken      : taken branch resolved in EXE
//  mem_r_en/mem_w_en : MEM stage load/store active
//  sram_ready        : SRAM access completes this cycle
//  cnt_clr           : clear all performance counters
//  freeze_*/flush_*/bubble_mem_wb : per-register controls (combinational)
//  in_mem_wait       : MEM access has already stalled at least one cycle and is still stalling
//  timeout_err       : sticky, MEM stall reached MEM_TIMEOUT consecutive cycles
//  deadlock_err      : sticky, hazard stall reached HAZ_MAX consecutive cycles
//  stall_cycles/flush_events/mem_wait_cycles : saturating performance counters
//
// Per-cycle priority: mem_stall > branch_taken > hazard_detected.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int HAZ_MAX     = DEF_HAZ_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             freeze_id_exe,
  output logic             flush_id_exe,
  output logic             freeze_exe_mem,
  output logic             bubble_mem_wb,
  output logic             in_mem_wait,
  output logic             timeout_err,
  output logic             deadlock_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  localparam int MW_W = $clog2(MEM_TIMEOUT + 1);
  localparam int HW_W = $clog2(HAZ_MAX + 1);
  localparam logic [MW_W-1:0] MEM_LIMIT = MW_W'(MEM_TIMEOUT);
  localparam logic [HW_W-1:0] HAZ_LIMIT = HW_W'(HAZ_MAX);

  ctrl_state_e     state;
  logic [MW_W-1:0] mem_wd;
  logic [HW_W-1:0] haz_wd;

  logic mem_stall;
  logic branch_flush;
  logic hazard_stall;

  // A branch seen while MEM is stalled is not latched: EXE is frozen so
  // branch_taken stays asserted and is serviced on the sram_ready cycle.
  assign mem_stall    = (mem_r_en | mem_w_en) & ~sram_ready;
  assign branch_flush = branch_taken & ~mem_stall;
  assign hazard_stall = hazard_detected & ~mem_stall & ~branch_taken;

  // A register is never frozen and flushed in the same cycle: the three
  // cases above are mutually exclusive and each sets a disjoint pattern.
  always_comb begin
    freeze_pc      = mem_stall | hazard_stall;
    freeze_if_id   = mem_stall | hazard_stall;
    flush_if_id    = branch_flush;
    freeze_id_exe  = mem_stall;
    flush_id_exe   = branch_flush | hazard_stall;  // hazard inserts a bubble into EXE
    freeze_exe_mem = mem_stall;
    bubble_mem_wb  = mem_stall;
  end

  // The ready cycle is the exit cycle and is already reported as RUN, so
  // the state register is qualified with the live stall condition.
  assign in_mem_wait = (state == MEM_WAIT) && mem_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      mem_wd       <= '0;
      haz_wd       <= '0;
      timeout_err  <= 1'b0;
      deadlock_err <= 1'b0;
    end else begin
      unique case (state)
        RUN:      if (mem_stall)  state <= MEM_WAIT;
        MEM_WAIT: if (!mem_stall) state <= RUN;
        default:  state <= RUN;
      endcase

      // Watchdogs hold at their limit; the error is raised on the edge that
      // closes the limit-th consecutive stall cycle and stays until rst.
      if (mem_stall) begin
        if (mem_wd != MEM_LIMIT) mem_wd <= mem_wd + 1'b1;
        if (mem_wd >= MEM_LIMIT - 1'b1) timeout_err <= 1'b1;
      end else begin
        mem_wd <= '0;
      end

      if (hazard_stall) begin
        if (haz_wd != HAZ_LIMIT) haz_wd <= haz_wd + 1'b1;
        if (haz_wd >= HAZ_LIMIT - 1'b1) deadlock_err <= 1'b1;
      end else begin
        haz_wd <= '0;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .inc (hazard_stall), .clr (cnt_clr), .q (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (branch_flush), .clr (cnt_clr), .q (flush_events)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
    .clk (clk), .rst (rst), .inc (mem_stall), .clr (cnt_clr), .q (mem_wait_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller. Narrow counters (4 bits) so
// saturation is reached quickly; watchdog limits at their defaults.
module tb_pipeline_stall_controller;

  localparam int TB_CNT_W    = 4;
  localparam int TB_TIMEOUT  = 64;
  localparam int TB_HAZ_MAX  = 8;
  localparam int CNT_SAT     = (1 << TB_CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready, cnt_clr;
  logic freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe;
  logic freeze_exe_mem, bubble_mem_wb, in_mem_wait, timeout_err, deadlock_err;
  logic [TB_CNT_W-1:0] stall_cycles, flush_events, mem_wait_cycles;

  pipeline_stall_controller #(
    .CNT_W(TB_CNT_W), .MEM_TIMEOUT(TB_TIMEOUT), .HAZ_MAX(TB_HAZ_MAX)
  ) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready), .cnt_clr(cnt_clr),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .freeze_id_exe(freeze_id_exe), .flush_id_exe(flush_id_exe),
    .freeze_exe_mem(freeze_exe_mem), .bubble_mem_wb(bubble_mem_wb),
    .in_mem_wait(in_mem_wait), .timeout_err(timeout_err), .deadlock_err(deadlock_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_wait_cycles(mem_wait_cycles)
  );

  // control vector order: freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe,
  // flush_id_exe, freeze_exe_mem, bubble_mem_wb
  logic [6:0] ctl;
  assign ctl = {freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe,
                flush_id_exe, freeze_exe_mem, bubble_mem_wb};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks run lengths of consecutive stall kinds and plain integer counts.
  int m_mem_run, m_haz_run, m_stall_cnt, m_flush_cnt, m_mem_cnt;
  bit m_tout, m_dead;
  logic [6:0] e_ctl;
  logic       e_wait;

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : CNT_SAT;
  endfunction

  // Classify this cycle by the priority rules and list the expected controls.
  task automatic model_eval();
    bit ms, br, hz;
    ms = (mem_r_en | mem_w_en) & ~sram_ready;
    br = branch_taken & ~ms;
    hz = hazard_detected & ~ms & ~branch_taken;
    if (ms)      e_ctl = 7'b1101011;
    else if (br) e_ctl = 7'b0010100;
    else if (hz) e_ctl = 7'b1100100;
    else         e_ctl = 7'b0000000;
    e_wait = ms && (m_mem_run > 0);
  endtask

  task automatic model_commit();
    bit ms, br, hz;
    ms = (mem_r_en | mem_w_en) & ~sram_ready;
    br = branch_taken & ~ms;
    hz = hazard_detected & ~ms & ~branch_taken;
    if (rst) begin
      m_mem_run = 0; m_haz_run = 0; m_tout = 0; m_dead = 0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_mem_cnt = 0;
    end else begin
      if (cnt_clr) begin
        m_stall_cnt = 0; m_flush_cnt = 0; m_mem_cnt = 0;
      end else begin
        if (hz) m_stall_cnt = sat_inc(m_stall_cnt);
        if (br) m_flush_cnt = sat_inc(m_flush_cnt);
        if (ms) m_mem_cnt   = sat_inc(m_mem_cnt);
      end
      m_mem_run = ms ? m_mem_run + 1 : 0;
      m_haz_run = hz ? m_haz_run + 1 : 0;
      if (m_mem_run >= TB_TIMEOUT) m_tout = 1;
      if (m_haz_run >= TB_HAZ_MAX) m_dead = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic h, input logic b, input logic r, input logic w,
                       input logic s, input logic c);
    hazard_detected = h; branch_taken = b; mem_r_en = r; mem_w_en = w;
    sram_ready = s; cnt_clr = c;
  endtask

  // Move to the sampling point (negedge) and compute this cycle's expectations.
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  // Clock edge: the model takes the same edge, inputs change 1 time unit later.
  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    advance();
    advance();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 0);
    advance();
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (ctl !== 7'b0 || in_mem_wait !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got %b/%b want 0000000/0", ctl, in_mem_wait);
    end
    checks++;
    if ({timeout_err, deadlock_err} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b want 00", {timeout_err, deadlock_err});
    end
    checks++;
    if (stall_cycles !== '0 || flush_events !== '0 || mem_wait_cycles !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0",
                         stall_cycles, flush_events, mem_wait_cycles);
    end
    advance();
  endtask

  task automatic test_hazard();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 0);
      settle();
      checks++;
      if (ctl !== e_ctl || ctl !== 7'b1100100) begin
        errors++; $display("FAIL hazard_ctl cyc%0d got %b want %b", i, ctl, e_ctl);
      end
      advance();
    end
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (stall_cycles !== TB_CNT_W'(m_stall_cnt) || m_stall_cnt != 2) begin
      errors++; $display("FAIL hazard_cnt got %0d want 2", stall_cycles);
    end
    advance();
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    drive(1, 1, 0, 0, 1, 0);
    settle();
    checks++;
    if (ctl !== e_ctl || ctl !== 7'b0010100) begin
      errors++; $display("FAIL branch_ctl got %b want %b", ctl, e_ctl);
    end
    advance();
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (flush_events !== TB_CNT_W'(1) || stall_cycles !== '0) begin
      errors++; $display("FAIL branch_cnt got flush=%0d stall=%0d want 1 0",
                         flush_events, stall_cycles);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 1, 0, (i == 6), 0);
      settle();
      checks++;
      if (ctl !== e_ctl) begin
        errors++; $display("FAIL memwait_ctl cyc%0d got %b want %b", i, ctl, e_ctl);
      end
      checks++;
      if (in_mem_wait !== e_wait || e_wait !== (i >= 2 && i <= 5)) begin
        errors++; $display("FAIL memwait_state cyc%0d got %b want %b", i, in_mem_wait, e_wait);
      end
      advance();
    end
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (mem_wait_cycles !== TB_CNT_W'(5) || in_mem_wait !== 1'b0) begin
      errors++; $display("FAIL memwait_cnt got %0d/%b want 5/0", mem_wait_cycles, in_mem_wait);
    end
    advance();
    // single-cycle access never enters the wait state
    drive(0, 0, 1, 0, 1, 0);
    settle();
    checks++;
    if (ctl !== 7'b0 || in_mem_wait !== 1'b0) begin
      errors++; $display("FAIL single_cycle got %b/%b want 0000000/0", ctl, in_mem_wait);
    end
    advance();
  endtask

  task automatic test_mem_branch();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 1, (i == 4), 0);
      settle();
      checks++;
      if (ctl !== e_ctl || flush_if_id !== (i == 4)) begin
        errors++; $display("FAIL membranch_ctl cyc%0d got %b want %b", i, ctl, e_ctl);
      end
      advance();
    end
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (flush_events !== TB_CNT_W'(1)) begin
      errors++; $display("FAIL membranch_cnt got %0d want 1", flush_events);
    end
    advance();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 71; i++) begin
      drive(0, 0, 1, 0, (i == 71), 0);
      settle();
      checks++;
      if (timeout_err !== m_tout || ctl !== e_ctl) begin
        errors++; $display("FAIL timeout cyc%0d got err=%b ctl=%b want err=%b ctl=%b",
                           i, timeout_err, ctl, m_tout, e_ctl);
      end
      advance();
    end
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (timeout_err !== 1'b1 || mem_wait_cycles !== TB_CNT_W'(CNT_SAT)) begin
      errors++; $display("FAIL timeout_hold got err=%b cnt=%0d want 1 %0d",
                         timeout_err, mem_wait_cycles, CNT_SAT);
    end
    advance();
    do_reset();
    settle();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_rst got %b want 0", timeout_err);
    end
    advance();
  endtask

  task automatic test_deadlock();
    do_reset();
    // one branch first so cnt_clr is seen clearing more than one counter
    drive(0, 1, 0, 0, 1, 0);
    advance();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 0, 0, 1, 0);
      settle();
      checks++;
      if (deadlock_err !== m_dead || stall_cycles !== TB_CNT_W'(m_stall_cnt)) begin
        errors++; $display("FAIL deadlock cyc%0d got err=%b cnt=%0d want err=%b cnt=%0d",
                           i, deadlock_err, stall_cycles, m_dead, m_stall_cnt);
      end
      advance();
    end
    drive(0, 0, 0, 0, 1, 1);
    settle();
    checks++;
    if (stall_cycles !== TB_CNT_W'(CNT_SAT) || deadlock_err !== 1'b1) begin
      errors++; $display("FAIL deadlock_sat got cnt=%0d err=%b want %0d 1",
                         stall_cycles, deadlock_err, CNT_SAT);
    end
    advance();
    // cnt_clr beats a same-cycle increment
    drive(1, 0, 0, 0, 1, 1);
    advance();
    drive(0, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (stall_cycles !== '0 || flush_events !== '0 || deadlock_err !== 1'b1) begin
      errors++; $display("FAIL cnt_clr got stall=%0d flush=%0d err=%b want 0 0 1",
                         stall_cycles, flush_events, deadlock_err);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      settle();
      checks++;
      if (ctl !== e_ctl || in_mem_wait !== e_wait) begin
        errors++; $display("FAIL random_ctl cyc%0d got %b/%b want %b/%b",
                           i, ctl, in_mem_wait, e_ctl, e_wait);
      end
      checks++;
      if (stall_cycles !== TB_CNT_W'(m_stall_cnt) || flush_events !== TB_CNT_W'(m_flush_cnt) ||
          mem_wait_cycles !== TB_CNT_W'(m_mem_cnt) || timeout_err !== m_tout ||
          deadlock_err !== m_dead) begin
        errors++; $display("FAIL random_state cyc%0d got %0d %0d %0d %b%b want %0d %0d %0d %b%b",
                           i, stall_cycles, flush_events, mem_wait_cycles, timeout_err,
                           deadlock_err, m_stall_cnt, m_flush_cnt, m_mem_cnt, m_tout, m_dead);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    m_mem_run = 0; m_haz_run = 0; m_tout = 0; m_dead = 0;
    m_stall_cnt = 0; m_flush_cnt = 0; m_mem_cnt = 0;
    #1;
    test_reset();
    test_hazard();
    test_branch_over_hazard();
    test_mem_wait();
    test_mem_branch();
    test_timeout();
    test_deadlock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
